// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one combinational 8x8 multiplier between two requesters
module mul_share_arb #(
  parameter int SETTLE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic [7:0]  A0,
  input  logic [7:0]  B0,
  input  logic        REQ1,
  input  logic [7:0]  A1,
  input  logic [7:0]  B1,
  input  logic [15:0] MZ,
  output logic [7:0]  MX,
  output logic [7:0]  MY,
  output logic [15:0] Z,
  output logic        DONE0,
  output logic        DONE1,
  output logic        GNT,
  output logic        BUSY
);
  localparam int S = SETTLE < 1 ? 1 : SETTLE;
  localparam int CW = S > 1 ? $clog2(S) : 1;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic ptr, win, grant, cap;
  // next state, tie-break winner and product capture strobe
  always_comb begin
    grant = state == IDLE && (REQ0 || REQ1);
    cap = state == RUN && cnt == '0;
    win = (REQ0 && REQ1) ? ptr : REQ1;
    state_n = grant ? RUN : cap ? RESP : state == RESP ? IDLE : state;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  // operand latch, settle counter, product capture and handshake outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      MX <= '0;
      MY <= '0;
      Z <= '0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      GNT <= 1'b0;
      BUSY <= 1'b0;
      ptr <= 1'b0;
      cnt <= '0;
    end else begin
      if (grant) begin
        MX <= win ? A1 : A0;
        MY <= win ? B1 : B0;
        GNT <= win;
        ptr <= ~win;
        cnt <= CW'(S - 1);
        BUSY <= 1'b1;
      end
      if (state == RUN && cnt != '0) cnt <= cnt - 1'b1;
      if (cap) begin
        Z <= MZ;
        DONE0 <= ~GNT;
        DONE1 <= GNT;
      end
      if (state == RESP) begin
        DONE0 <= 1'b0;
        DONE1 <= 1'b0;
        BUSY <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed self-checking bench for the shared multiplier arbiter
module tb_mul_share_arb;
  logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, mx, my;
  logic [15:0] mz, z;
  logic done0, done1, gnt, busy;
  int checks = 0, errors = 0;
  int n;

  assign mz = {8'd0, mx} * {8'd0, my};

  mul_share_arb #(.SETTLE(2)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .A0(a0), .B0(b0), .REQ1(req1), .A1(a1), .B1(b1),
    .MZ(mz), .MX(mx), .MY(my), .Z(z), .DONE0(done0), .DONE1(done1), .GNT(gnt), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) check("done_excl", 32'(done0 & done1), 0);

  task automatic wait_done(input bit idx, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(idx ? done1 : done0) && cyc < 20);
    check("done_seen", 32'(idx ? done1 : done0), 1);
  endtask

  task automatic op(input bit idx, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int c;
    if (idx) begin req1 = 1'b1; a1 = a; b1 = b; end
    else begin req0 = 1'b1; a0 = a; b0 = b; end
    wait_done(idx, c);
    check("latency", c, 3);
    check("z", 32'(z), 32'(exp));
    check("gnt", 32'(gnt), 32'(idx));
    check("busy_resp", 32'(busy), 1);
    check("mx", 32'(mx), 32'(a));
    check("my", 32'(my), 32'(b));
    if (idx) req1 = 1'b0;
    else req0 = 1'b0;
    @(negedge clk);
    check("done_clr", 32'(idx ? done1 : done0), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_z", 32'(z), 0);
    check("rst_done", 32'({done0, done1}), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_mxmy", 32'({mx, my}), 0);
    rst = 1'b0;
    // T1 single request
    op(1'b0, 8'd53, 8'd78, 16'h1026);
    // T2 simultaneous requests after reset: requester 0 first
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
    req1 = 1'b1; a1 = 8'd255; b1 = 8'd255;
    wait_done(1'b0, n);
    check("t2_lat0", n, 3);
    check("t2_z0", 32'(z), 15);
    req0 = 1'b0;
    wait_done(1'b1, n);
    check("t2_gap", n, 4);
    check("t2_z1", 32'(z), 32'h0000fe01);
    check("t2_gnt1", 32'(gnt), 1);
    req1 = 1'b0;
    @(negedge clk);
    // T3 both held: grants alternate
    a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done(i[0], n);
      check("t3_gap", n, i == 0 ? 3 : 4);
      check("t3_gnt", 32'(gnt), 32'(i[0]));
      check("t3_z", 32'(z), i[0] ? 20 : 6);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    // T4 zero product then small product, Z holds in between
    op(1'b1, 8'd0, 8'd200, 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("t4_hold", 32'(z), 0);
    end
    op(1'b1, 8'd1, 8'd11, 16'd11);
    // T5 reset during RUN aborts
    req0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
    @(negedge clk);
    check("t5_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("t5_busy_rst", 32'(busy), 0);
    check("t5_z_rst", 32'(z), 0);
    check("t5_done_rst", 32'(done0), 0);
    check("t5_mx_rst", 32'(mx), 0);
    rst = 1'b0;
    op(1'b0, 8'd7, 8'd9, 16'd63);
    // T6 request dropped and operand changed during RUN
    req0 = 1'b1; a0 = 8'd53; b0 = 8'd78;
    @(negedge clk);
    req0 = 1'b0; a0 = 8'd99;
    wait_done(1'b0, n);
    check("t6_lat", n, 2);
    check("t6_z", 32'(z), 32'h00001026);
    @(negedge clk);
    check("t6_idle", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
